spi_master: RTL and testbench

- SPI mode-0 initiator that issues one register-file or FIFO access frame on `ssn`/`sclk`/`mosi` and captures read data from `miso`.
- The frame targets the board's SPI slave receive/transmit pair. Address bit 7 = 1 selects the FIFO; the master treats the address as opaque.
- Sits on the 100 MHz system clock; driven by a host-side start/done handshake.

---
 rtl/spi_master.sv | 166 ++++++++++++++++
 tb/tb_spi_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one 32-bit frame (16-bit header, turnaround, 16-bit data)
// per accepted start, with a 2-flop miso synchronizer and read-data capture.
module spi_master #(
  parameter int SCLK_DIV  = 5,
  parameter int SSN_SETUP = 4,
  parameter int TA_CYCLES = 20,
  parameter int SSN_HOLD  = 4,
  parameter int SSN_GAP   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        ssn,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP      = 3'd1,
    SHIFT_HDR  = 3'd2,
    TURNAROUND = 3'd3,
    SHIFT_DATA = 3'd4,
    HOLD       = 3'd5,
    GAP        = 3'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic          sclk_hi;
  logic [31:0]   tx_sh;
  logic          rw_q;
  logic          miso_s1;
  logic          miso_s2;
  logic [1:0]    cap_pipe;
  logic [15:0]   rx_sh;
  logic [15:0]   rx_in;

  logic in_shift;
  logic half_end;
  logic fall_now;
  logic bit_end;
  logic last_bit;

  assign in_shift = (state == SHIFT_HDR) || (state == SHIFT_DATA);
  assign half_end = (cnt == CW'(SCLK_DIV - 1));
  assign fall_now = in_shift && half_end && sclk_hi;
  assign bit_end  = in_shift && half_end && !sclk_hi;
  assign last_bit = bit_end && (bit_cnt == 5'd15);
  assign rx_in    = {rx_sh[14:0], miso_s2};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start)                          state_next = SETUP;
      SETUP:      if (cnt == CW'(SSN_SETUP - 1))      state_next = SHIFT_HDR;
      SHIFT_HDR:  if (last_bit)                       state_next = TURNAROUND;
      TURNAROUND: if (cnt == CW'(TA_CYCLES - 1))      state_next = SHIFT_DATA;
      SHIFT_DATA: if (last_bit)                       state_next = HOLD;
      HOLD:       if (cnt == CW'(SSN_HOLD - 1))       state_next = GAP;
      GAP:        if (cnt == CW'(SSN_GAP - 1))        state_next = IDLE;
      default:                                        state_next = IDLE;
    endcase
  end

  // Timing counters and serial clock phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sclk_hi <= 1'b0;
    end else if (state_next != state) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sclk_hi <= (state_next == SHIFT_HDR) || (state_next == SHIFT_DATA);
    end else if (state == IDLE) begin
      cnt     <= '0;
    end else if (in_shift && half_end) begin
      cnt     <= '0;
      sclk_hi <= !sclk_hi;
      if (bit_end) bit_cnt <= bit_cnt + 5'd1;
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

  // Transmit shift register: advances only as sclk falls, so mosi is stable at every rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_sh <= '0;
      rw_q  <= 1'b0;
    end else if (state == IDLE && start) begin
      tx_sh <= {addr, rw, 7'd0, (rw ? 16'd0 : wdata)};
      rw_q  <= rw;
    end else if (fall_now) begin
      tx_sh <= {tx_sh[30:0], 1'b0};
    end
  end

  // The capture strobe is delayed by the synchronizer depth, so the bit shifted in
  // is the one miso carried during the last clk of the sclk high phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miso_s1  <= 1'b0;
      miso_s2  <= 1'b0;
      cap_pipe <= '0;
      rx_sh    <= '0;
    end else begin
      miso_s1  <= miso;
      miso_s2  <= miso_s1;
      cap_pipe <= {cap_pipe[0], (state == SHIFT_DATA) && fall_now};
      if (cap_pipe[1]) rx_sh <= rx_in;
    end
  end

  // rdata is published once, when ssn rises; the last capture may land on that same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (state == HOLD && state_next == GAP && rw_q) begin
      rdata <= cap_pipe[1] ? rx_in : rx_sh;
    end
  end

  // Output decode
  always_comb begin
    ssn  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    busy = (state != IDLE);
    done = (state == GAP) && (cnt == '0);
    case (state)
      SETUP, TURNAROUND, HOLD: begin
        ssn  = 1'b0;
        mosi = tx_sh[31];
      end
      SHIFT_HDR, SHIFT_DATA: begin
        ssn  = 1'b0;
        mosi = tx_sh[31];
        sclk = sclk_hi;
      end
      default: begin
        ssn  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: directed and random frames against a frame-level model,
// plus a second instance with the fastest legal timing.
module tb_spi_master;

  localparam int DIV      = 5;
  localparam int SETUP    = 4;
  localparam int TA       = 20;
  localparam int HOLD     = 4;
  localparam int GAP      = 10;
  localparam int LOW_DEF  = SETUP + 64 * DIV + TA + HOLD;
  localparam int LOW_FAST = 4 + 64 * 1 + 1 + 4;
  localparam int BUDGET   = 2000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  logic        start = 1'b0, rw = 1'b0;
  logic [7:0]  addr  = '0;
  logic [15:0] wdata = '0;
  logic        busy, done, ssn, sclk, mosi;
  logic        miso = 1'b0;
  logic [15:0] rdata;

  logic        f_start = 1'b0, f_rw = 1'b0;
  logic [7:0]  f_addr  = '0;
  logic [15:0] f_wdata = '0;
  logic        f_busy, f_done, f_ssn, f_sclk, f_mosi;
  logic        f_miso = 1'b0;
  logic [15:0] f_rdata;

  spi_master u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ssn(ssn), .sclk(sclk), .mosi(mosi),
    .miso(miso)
  );

  spi_master #(.SCLK_DIV(1), .TA_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .start(f_start), .rw(f_rw), .addr(f_addr), .wdata(f_wdata),
    .busy(f_busy), .done(f_done), .rdata(f_rdata), .ssn(f_ssn), .sclk(f_sclk), .mosi(f_mosi),
    .miso(f_miso)
  );

  // ---------------- line monitor + slave model (main DUT) ----------------
  logic [31:0] rd_word = '0;
  logic [31:0] mosi_word = '0;
  logic        p_ssn = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
  int low_cnt = 0, last_low = 0, hi_cnt = 0, last_hi = 0;
  int rise_cnt = 0, nfall = 0, ssn_falls = 0;
  int done_cnt = 0, done_bad = 0, stray_rise = 0, mosi_bad = 0;

  always @(negedge clk) begin
    if (!ssn) low_cnt++; else hi_cnt++;
    if (ssn && !p_ssn) begin
      last_low = low_cnt;
      low_cnt  = 0;
    end
    if (!ssn && p_ssn) begin
      last_hi   = hi_cnt;
      hi_cnt    = 0;
      ssn_falls++;
      rise_cnt  = 0;
      nfall     = 0;
      mosi_word = '0;
    end
    if (sclk && !p_sclk) begin
      if (ssn) stray_rise++;
      else begin
        mosi_word = {mosi_word[30:0], mosi};
        rise_cnt++;
      end
    end
    if (!sclk && p_sclk && !ssn) begin
      nfall++;
      if (nfall >= 16 && nfall <= 31) miso = rd_word[31 - nfall];
    end
    if (mosi !== p_mosi && !ssn && !p_ssn && !(p_sclk && !sclk)) mosi_bad++;
    if (done) begin
      done_cnt++;
      if (!(ssn && !p_ssn)) done_bad++;
    end
    p_ssn  = ssn;
    p_sclk = sclk;
    p_mosi = mosi;
  end

  // ---------------- line monitor + slave model (fast DUT) ----------------
  logic [31:0] f_rd_word = '0;
  logic [31:0] f_word = '0;
  logic        f_p_ssn = 1'b1, f_p_sclk = 1'b0;
  int f_low_cnt = 0, f_last_low = 0, f_nfall = 0, f_done_cnt = 0;

  always @(negedge clk) begin
    if (!f_ssn) f_low_cnt++;
    if (f_ssn && !f_p_ssn) begin
      f_last_low = f_low_cnt;
      f_low_cnt  = 0;
    end
    if (!f_ssn && f_p_ssn) begin
      f_word  = '0;
      f_nfall = 0;
    end
    if (f_sclk && !f_p_sclk && !f_ssn) f_word = {f_word[30:0], f_mosi};
    if (!f_sclk && f_p_sclk && !f_ssn) begin
      f_nfall++;
      if (f_nfall >= 16 && f_nfall <= 31) f_miso = f_rd_word[31 - f_nfall];
    end
    if (f_done) f_done_cnt++;
    f_p_ssn  = f_ssn;
    f_p_sclk = f_sclk;
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frame_word(input logic r, input logic [7:0] a, input logic [15:0] wd);
    return {a, r, 7'h00, (r ? 16'h0000 : wd)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit fast, input string tag);
    int n;
    n = 0;
    while ((fast ? f_done : done) !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/done_timeout"}, (n < BUDGET) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic frame(input logic t_rw, input logic [7:0] t_addr, input logic [15:0] t_wdata,
                       input logic [15:0] slave_data, input string tag);
    int d0;
    rd_word = {16'h0, slave_data};
    exp_q.push_back(frame_word(t_rw, t_addr, t_wdata));
    if (t_rw) exp_rdata = slave_data;
    d0 = done_cnt;
    @(posedge clk); #1;
    rw = t_rw; addr = t_addr; wdata = t_wdata; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "/busy_after_start"}, 32'(busy), 32'd1);
    wait_done(1'b0, tag);
    repeat (GAP + 3) @(negedge clk);
    #1;
    check({tag, "/done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "/mosi_frame"}, mosi_word, exp_q.pop_front());
    check({tag, "/ssn_low_cycles"}, 32'(last_low), 32'(LOW_DEF));
    check({tag, "/sclk_rises"}, 32'(rise_cnt), 32'd32);
    check({tag, "/rdata"}, 32'(rdata), 32'(exp_rdata));
    check({tag, "/busy_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0, f0, n;
    logic [7:0]  ra;
    logic [15:0] rw16, rs16;
    logic        rr;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst/ssn", 32'(ssn), 32'd1);
    check("rst/sclk", 32'(sclk), 32'd0);
    check("rst/mosi", 32'(mosi), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // plain write and FIFO read
    frame(1'b0, 8'h12, 16'hBEEF, 16'h0000, "write12");
    frame(1'b1, 8'h85, 16'h1357, 16'hA5C3, "read85");

    // start held high: write then read back-to-back
    d0 = done_cnt;
    f0 = ssn_falls;
    rd_word = 32'h0000_1234;
    @(posedge clk); #1;
    rw = 1'b0; addr = 8'h3C; wdata = 16'h55AA; start = 1'b1;
    wait_done(1'b0, "held1");
    #1;
    check("held1/mosi_frame", mosi_word, frame_word(1'b0, 8'h3C, 16'h55AA));
    rw = 1'b1; addr = 8'h90;
    @(negedge clk);
    wait_done(1'b0, "held2");
    start = 1'b0;
    exp_rdata = 16'h1234;
    repeat (GAP + 3) @(negedge clk);
    #1;
    check("held2/mosi_frame", mosi_word, frame_word(1'b1, 8'h90, 16'h55AA));
    check("held/gap_ge_ssn_gap", (last_hi >= GAP) ? 32'd1 : 32'd0, 32'd1);
    check("held/done_pulses", 32'(done_cnt - d0), 32'd2);
    check("held/frames", 32'(ssn_falls - f0), 32'd2);
    check("held/rdata", 32'(rdata), 32'(exp_rdata));

    // start pulsed mid-frame is ignored
    d0 = done_cnt;
    f0 = ssn_falls;
    @(posedge clk); #1;
    rw = 1'b0; addr = 8'h21; wdata = 16'h0F0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rw = 1'b1; addr = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midstart/busy", 32'(busy), 32'd1);
    wait_done(1'b0, "midstart");
    repeat (GAP + 30) @(negedge clk);
    #1;
    check("midstart/mosi_frame", mosi_word, frame_word(1'b0, 8'h21, 16'h0F0F));
    check("midstart/frames", 32'(ssn_falls - f0), 32'd1);
    check("midstart/done_pulses", 32'(done_cnt - d0), 32'd1);
    check("midstart/rdata", 32'(rdata), 32'(exp_rdata));

    // reset asserted during the data phase
    @(posedge clk); #1;
    rw = 1'b0; addr = 8'h44; wdata = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (rise_cnt != 22 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("abort/reach_data_bit5", (n < BUDGET) ? 32'd1 : 32'd0, 32'd1);
    #2;
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    exp_rdata = '0;
    check("abort/ssn", 32'(ssn), 32'd1);
    check("abort/sclk", 32'(sclk), 32'd0);
    check("abort/mosi", 32'(mosi), 32'd0);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/rdata", 32'(rdata), 32'(exp_rdata));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("abort/no_done", 32'(done_cnt - d0), 32'd0);
    frame(1'b0, 8'h01, 16'h0001, 16'h0000, "after_abort");

    // random frames
    for (int i = 0; i < 5; i++) begin
      rr   = 1'($urandom_range(0, 1));
      ra   = 8'($urandom_range(0, 255));
      rw16 = 16'($urandom_range(0, 65535));
      rs16 = 16'($urandom_range(0, 65535));
      frame(rr, ra, rw16, rs16, $sformatf("rand%0d", i));
    end

    // fastest timing: SCLK_DIV=1, TA_CYCLES=1
    d0 = f_done_cnt;
    f_rd_word = 32'h0000_7E81;
    @(posedge clk); #1;
    f_rw = 1'b1; f_addr = 8'h3C; f_wdata = 16'hFFFF; f_start = 1'b1;
    @(posedge clk); #1;
    f_start = 1'b0;
    check("fast/busy_after_start", 32'(f_busy), 32'd1);
    wait_done(1'b1, "fast");
    repeat (GAP + 3) @(negedge clk);
    #1;
    check("fast/rdata", 32'(f_rdata), 32'h7E81);
    check("fast/ssn_low_cycles", 32'(f_last_low), 32'(LOW_FAST));
    check("fast/mosi_frame", f_word, frame_word(1'b1, 8'h3C, 16'hFFFF));
    check("fast/done_pulses", 32'(f_done_cnt - d0), 32'd1);

    // line-level rules accumulated over the whole run
    check("line/done_not_at_ssn_rise", 32'(done_bad), 32'd0);
    check("line/sclk_rise_outside_ssn", 32'(stray_rise), 32'd0);
    check("line/mosi_change_off_fall", 32'(mosi_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
